// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program-counter sequencer with branch-target LUT
//
// Purpose: drives the instruction-ROM address through an IDLE/RUN/HALT
// sequence. Branch targets are absolute addresses held in a small LUT that
// is loaded while IDLE and read while RUN.
//
// Ports:
//   CLK          sole clock, rising edge
//   Reset        synchronous active-high reset (clears state, PC, count, LUT)
//   Start        start request, sampled in IDLE and HALT
//   stall        freeze PC/state/count for this RUN cycle
//   branch_en    current instruction is a conditional branch
//   branch_sense flag polarity that makes the branch taken
//   FLAG_IN      registered compare flag
//   target_idx   LUT index of the branch target
//   halt_req     current instruction is halt
//   lut_we       LUT write strobe (IDLE only)
//   lut_addr     LUT write index
//   lut_data     LUT write data
//   PC           registered instruction address
//   fetch_valid  high in RUN
//   Done         high in HALT
//   instr_count  saturating count of retired instructions since Start

module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            branch_sense,
  input  logic            FLAG_IN,
  input  logic [2:0]      target_idx,
  input  logic            halt_req,
  input  logic            lut_we,
  input  logic [2:0]      lut_addr,
  input  logic [PC_W-1:0] lut_data,
  output logic [PC_W-1:0] PC,
  output logic            fetch_valid,
  output logic            Done,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_d [LUT_DEPTH];
  logic            taken;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      lut_q   <= lut_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    lut_d   = lut_q;
    taken   = branch_en & (FLAG_IN == branch_sense);

    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (lut_we) begin
          lut_d[lut_addr] = lut_data;
        end
        if (Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        if (!stall) begin
          // Every non-stalled RUN cycle retires one instruction, halt included.
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          // Halt beats branch: PC stays on the halt instruction.
          if (halt_req) begin
            state_d = S_HALT;
          end else if (taken) begin
            pc_d = lut_q[target_idx];
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end

      S_HALT: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign PC          = pc_q;
  assign fetch_valid = (state_q == S_RUN);
  assign Done        = (state_q == S_HALT);
  assign instr_count = cnt_q;

endmodule
